spi_transaction_fsm: RTL
========================

// Module: spi_transaction_fsm
// PURPOSE
//   Sequencer for one SPI memory slave transaction. Counts SCLK edge pulses from the input
//   conditioners and drives the shift register (parallelLoad), address latch, data-memory
//   write enable and MISO tri-state enable. Frame: 7-bit address MSB-first, then R/W bit
//   (1=read), then 8 data bits. Sits between the input conditioners and the datapath.
// PARAMETERS
//   ADDR_BITS  7  address field width; command = ADDR_BITS+1 bits (localparam CMD_BITS)
//   DATA_BITS  8  data field width; equals the shift register width
// PORTS
//   clk            in   1  FPGA clock; all state changes on posedge
//   reset          in   1  asynchronous, active-high; forces IDLE, all outputs 0
//   cs_n           in   1  chip select, active low, already synchronised
//   sclk_pos_edge  in   1  one-clk pulse per SCLK rising edge
//   sclk_neg_edge  in   1  one-clk pulse per SCLK falling edge
//   rw_bit         in   1  shift register parallelDataOut[0]
//   sr_load        out  1  drives shift register parallelLoad
//   addr_we        out  1  address latch enable
//   dm_we          out  1  data memory write enable
//   miso_bufe      out  1  MISO tri-state buffer enable
//   busy           out  1  high in every state except IDLE
// BEHAVIOUR
//   - Reset: state=IDLE, bit counter=0, all outputs 0. Effective immediately, mid-frame too.
//   - Outputs are registered Moore decodes of state; no combinational path from inputs.
//   - States and transitions:
//     IDLE     : cs_n==0 -> GET_ADDR, counter cleared. Edge pulses ignored.
//     GET_ADDR : count sclk_pos_edge; on CMD_BITS-th pulse -> ADDR_WAIT.
//     ADDR_WAIT: 1 clk, absorbs the 2-clk shift register latency -> GOT_ADDR.
//     GOT_ADDR : addr_we=1 for exactly 1 clk; sample rw_bit: 1 -> READ_LOAD, 0 -> WRITE_RECV.
//     READ_LOAD: sr_load=1 for exactly 1 clk (memory read data valid) -> READ_SHIFT.
//     READ_SHIFT: miso_bufe=1; count sclk_neg_edge; on DATA_BITS-th pulse -> DONE.
//     WRITE_RECV: count sclk_pos_edge; on DATA_BITS-th pulse -> WRITE_WAIT.
//     WRITE_WAIT: 1 clk latency absorb -> WRITE_COMMIT.
//     WRITE_COMMIT: dm_we=1 for exactly 1 clk -> DONE.
//     DONE     : all outputs 0 except busy; wait for cs_n==1 -> IDLE.
//   - Abort: cs_n==1 in any non-IDLE state -> IDLE next clk. Abort takes priority over an
//     edge pulse in the same cycle. Abort before WRITE_COMMIT gives no dm_we pulse.
//   - Counter resets to 0 on every state entry. Width $clog2(max(CMD_BITS,DATA_BITS)+1).
//     It never wraps: the terminal pulse always leaves the state.
//   - Extra SCLK edges in DONE are ignored; no second transaction without a cs_n de-assert.
//   - Edge pulse in the cycle of a transition is credited to the new state only if that state
//     counts it. Example: pos edge in ADDR_WAIT is not counted.
//   - sclk_pos_edge and sclk_neg_edge both high (illegal): only the state-relevant one is used.
// STRUCTURE
//   - Shared package/header spi_defs: state encoding localparams (4-bit, IDLE=0), CMD_BITS,
//     and the R/W encoding (READ=1).
//   - One sub-module, spi_bit_counter: clear, enable and terminal-count compare, parameterised
//     width. FSM next-state and output decode stay in this module.
// TESTING
//   1 Read: cs_n low, 8 pos edges shifting 0x55 (addr 0x2A, rw=1) -> addr_we 1 clk, 3 clk after
//     8th edge; sr_load 1 clk later; miso_bufe high until 8th neg edge; dm_we never high.
//   2 Write: 0x54 then data 0xA3 -> addr_we once; dm_we exactly 1 clk, 3 clk after 16th pos
//     edge; miso_bufe and sr_load never high.
//   3 Abort: cs_n high after 12 pos edges of a write -> IDLE next clk, busy=0, no dm_we; next
//     full write commits normally.
//   4 Reset mid-READ_SHIFT: assert reset between clk edges -> all outputs 0 at once, IDLE.
//   5 Coincidence: cs_n rises in the same clk as 16th write pos edge -> IDLE, dm_we stays 0.
//   6 Back-to-back: two reads with cs_n high for 1 clk between them -> both complete; 20
//     extra edges in DONE produce no output pulses.

Source files
------------

// File: rtl/spi_defs.sv
// Shared definitions for the SPI slave transaction sequencer: default field
// widths, the R/W bit encoding and the 4-bit state encoding (IDLE = 0).
package spi_defs;

  localparam int DEF_ADDR_BITS = 7;
  localparam int DEF_DATA_BITS = 8;
  localparam int CMD_BITS      = DEF_ADDR_BITS + 1;

  // Value of the R/W bit that requests a read from the slave.
  localparam logic RW_READ = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_GET_ADDR     = 4'd1,
    ST_ADDR_WAIT    = 4'd2,
    ST_GOT_ADDR     = 4'd3,
    ST_READ_LOAD    = 4'd4,
    ST_READ_SHIFT   = 4'd5,
    ST_WRITE_RECV   = 4'd6,
    ST_WRITE_WAIT   = 4'd7,
    ST_WRITE_COMMIT = 4'd8,
    ST_DONE         = 4'd9
  } state_t;

endpackage

// File: rtl/spi_bit_counter.sv
// Edge-pulse counter with synchronous clear, count enable and a
// terminal-count flag that fires on the pulse that reaches the terminal value.
module spi_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] terminal,
  output logic         done
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count;

  // Count qualifying pulses; clear wins so every state entry starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + ONE;
    end
  end

  // The terminal pulse itself raises done, so the owner leaves before any wrap.
  assign done = enable && (count == terminal - ONE);

endmodule

// File: rtl/spi_transaction_fsm.sv
// Sequencer for one SPI memory-slave transaction: 7-bit address MSB first,
// R/W bit (1 = read), then 8 data bits. Drives the shift register load,
// address latch enable, data memory write enable and MISO buffer enable.
//
// Handshake: there is no valid/ready pair here. sclk_pos_edge/sclk_neg_edge
// are single-cycle strobes that are consumed only in the state that counts
// them; cs_n high in any non-IDLE state aborts to IDLE on the next clock and
// outranks any strobe in the same cycle.
module spi_transaction_fsm
  import spi_defs::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input  logic clk,
  input  logic reset,
  input  logic cs_n,
  input  logic sclk_pos_edge,
  input  logic sclk_neg_edge,
  input  logic rw_bit,
  output logic sr_load,
  output logic addr_we,
  output logic dm_we,
  output logic miso_bufe,
  output logic busy
);

  localparam int CMD_LEN = ADDR_BITS + 1;
  localparam int CNT_MAX = (CMD_LEN > DATA_BITS) ? CMD_LEN : DATA_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state;
  state_t           next_state;
  logic             cnt_clear;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_term;
  logic             cnt_done;

  spi_bit_counter #(.W(CNT_W)) u_bit_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .terminal (cnt_term),
    .done     (cnt_done)
  );

  // Select which edge strobe the current state counts and its terminal count.
  always_comb begin
    cnt_en   = 1'b0;
    cnt_term = CNT_W'(DATA_BITS);
    case (state)
      ST_GET_ADDR: begin
        cnt_en   = sclk_pos_edge;
        cnt_term = CNT_W'(CMD_LEN);
      end
      ST_WRITE_RECV: cnt_en = sclk_pos_edge;
      ST_READ_SHIFT: cnt_en = sclk_neg_edge;
      default:       cnt_en = 1'b0;
    endcase
  end

  // Counter restarts on every state change and is held at zero while idle.
  assign cnt_clear = (next_state != state) || (state == ST_IDLE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a cs_n abort overrides whatever the state decided.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:         if (!cs_n) next_state = ST_GET_ADDR;
      ST_GET_ADDR:     if (cnt_done) next_state = ST_ADDR_WAIT;
      ST_ADDR_WAIT:    next_state = ST_GOT_ADDR;
      ST_GOT_ADDR:     next_state = (rw_bit == RW_READ) ? ST_READ_LOAD : ST_WRITE_RECV;
      ST_READ_LOAD:    next_state = ST_READ_SHIFT;
      ST_READ_SHIFT:   if (cnt_done) next_state = ST_DONE;
      ST_WRITE_RECV:   if (cnt_done) next_state = ST_WRITE_WAIT;
      ST_WRITE_WAIT:   next_state = ST_WRITE_COMMIT;
      ST_WRITE_COMMIT: next_state = ST_DONE;
      ST_DONE:         next_state = ST_DONE;
      default:         next_state = ST_IDLE;
    endcase
    if ((state != ST_IDLE) && cs_n) begin
      next_state = ST_IDLE;
    end
  end

  // Registered Moore outputs: decode of the state being entered, so each
  // output lines up with its state and never sees an input combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_we   <= 1'b0;
      sr_load   <= 1'b0;
      miso_bufe <= 1'b0;
      dm_we     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      addr_we   <= (next_state == ST_GOT_ADDR);
      sr_load   <= (next_state == ST_READ_LOAD);
      miso_bufe <= (next_state == ST_READ_SHIFT);
      dm_we     <= (next_state == ST_WRITE_COMMIT);
      busy      <= (next_state != ST_IDLE);
    end
  end

endmodule
